// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Optional feature macro: SCAN_DECODER_CNT_EN (word_cnt width lives here).
package scan_decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Width of the optional handshake counter output.
  localparam int WORD_CNT_W = 16;

endpackage : scan_decoder_pkg

// File: rtl/onehot_dec.sv
// Combinational SEL_W-to-2**SEL_W one-hot decoder with enable.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: sel_i (select), en_i (enable, 0 forces all-zero), y_o (one-hot word).
module onehot_dec #(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      sel_i,
  input  logic                  en_i,
  output logic [(2**SEL_W)-1:0] y_o
);

  localparam int OUT_W = 2**SEL_W;

  always_comb begin
    y_o = '0;
    if (en_i) begin
      y_o = OUT_W'(1) << sel_i;
    end
  end

endmodule : onehot_dec

// File: rtl/scan_decoder.sv
// One-hot decoder that emits either a single word or a scan of len+1 words
// from consecutive (wrapping) selects. Latency: 1 cycle from accept to the
// first word; scan words follow back-to-back while the consumer is ready.
// Backpressure: the single output register holds while out_valid && !out_ready;
// in_ready is low during a scan and while the output slot is occupied.
// Ports: clk/rst_n; command side en, in_valid, in_ready, mode, sel, len;
// output side out_valid, out_ready, y. With SCAN_DECODER_CNT_EN defined an
// extra word_cnt output counts output handshakes (saturating).
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [LEN_W-1:0]      len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [(2**SEL_W)-1:0] y
`ifdef SCAN_DECODER_CNT_EN
  ,
  output logic [WORD_CNT_W-1:0] word_cnt
`endif
);

  localparam int OUT_W = 2**SEL_W;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic [SEL_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               en_q, en_d;

  logic               slot_free;
  logic               accept;
  logic [SEL_W-1:0]   dec_sel;
  logic               dec_en;
  logic [OUT_W-1:0]   dec_y;

  // The slot is free when empty or when its word leaves this cycle, which is
  // what allows a new word to load in the same cycle as a handshake.
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;

  // One shared decoder: the command's select while idle, the scan address
  // (with the enable captured at accept) while scanning.
  assign dec_sel = (state_q == SCAN) ? addr_q : sel;
  assign dec_en  = (state_q == SCAN) ? en_q   : en;

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_onehot_dec (
    .sel_i (dec_sel),
    .en_i  (dec_en),
    .y_o   (dec_y)
  );

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    en_d        = en_q;

    // Consumed word drops out unless a new one is loaded below.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          y_d         = dec_y;
          out_valid_d = 1'b1;
          if (mode) begin
            addr_d      = sel + SEL_W'(1);
            remaining_d = len;
            en_d        = en;
            if (len != '0) begin
              state_d = SCAN;
            end
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          y_d         = dec_y;
          out_valid_d = 1'b1;
          addr_d      = addr_q + SEL_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          // Leave as the final word loads so the next command can be
          // accepted as soon as that word is taken.
          if (remaining_q == LEN_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      en_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      en_q        <= en_d;
    end
  end

  assign y         = y_q;
  assign out_valid = out_valid_q;

`ifdef SCAN_DECODER_CNT_EN
  logic [WORD_CNT_W-1:0] word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
    end else if (out_valid_q && out_ready && (word_cnt_q != '1)) begin
      word_cnt_q <= word_cnt_q + WORD_CNT_W'(1);
    end
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: commands push their expected words,
// a monitor pops and compares on every output handshake.
module tb_scan_decoder;

  localparam int SEL_W = 4;
  localparam int LEN_W = 4;
  localparam int OUT_W = 2**SEL_W;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [LEN_W-1:0] len;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] y;
`ifdef SCAN_DECODER_CNT_EN
  logic [15:0]      word_cnt;
`endif

  scan_decoder #(
    .SEL_W (SEL_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .len       (len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef SCAN_DECODER_CNT_EN
    ,
    .word_cnt  (word_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int hs_cnt = 0;
  logic [OUT_W-1:0] exp_q[$];
  bit rdy_rand = 1'b0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  // Reference model: a command yields len+1 words (1 for a single decode),
  // word i being the one-hot of (sel+i) mod OUT_W, or zero when disabled.
  function automatic void push_expected(logic m, int s, int l, logic e);
    int n;
    int idx;
    logic [OUT_W-1:0] w;
    n = m ? l + 1 : 1;
    for (int i = 0; i < n; i++) begin
      idx = (s + i) % OUT_W;
      w = '0;
      if (e) w[idx] = 1'b1;
      exp_q.push_back(w);
    end
  endfunction

  // Monitor: compares every handshake and checks that a stalled word holds.
  initial begin
    logic             prev_stall;
    logic [OUT_W-1:0] prev_y;
    logic [OUT_W-1:0] exp_w;
    prev_stall = 1'b0;
    prev_y = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        hs_cnt = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", {63'd0, out_valid}, 64'd1);
          check("hold_y", {48'd0, y}, {48'd0, prev_y});
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_word", {48'd0, y}, 64'hDEAD);
          end else begin
            exp_w = exp_q.pop_front();
            check("word", {48'd0, y}, {48'd0, exp_w});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_y = y;
      end
    end
  end

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic m, input int s, input int l, input logic e);
    int cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    mode = m;
    sel = SEL_W'(s);
    len = LEN_W'(l);
    en = e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cyc++;
      if (cyc > 300) begin
        check("issue_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    push_expected(m, s, l, e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready && !out_valid) return;
    end
    check("drain_timeout", 64'd0, 64'd1);
  endtask

  task automatic fixed_ready();
    rdy_rand = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    in_valid = 1'b0;
    mode = 1'b0;
    sel = '0;
    len = '0;
    out_ready = 1'b1;

    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_y", {48'd0, y}, 64'd0);
    #20;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    // Single decode, enabled: valid one cycle after accept.
    issue(1'b0, 5, 0, 1'b1);
    @(negedge clk);
    check("single_valid", {63'd0, out_valid}, 64'd1);
    check("single_y", {48'd0, y}, 64'h0020);
    wait_idle();

    // Single decode, disabled: one all-zero word.
    issue(1'b0, 9, 0, 1'b0);
    @(negedge clk);
    check("dis_valid", {63'd0, out_valid}, 64'd1);
    check("dis_y", {48'd0, y}, 64'h0000);
    wait_idle();

    // Wrapping scan with in_ready low while scanning.
    issue(1'b1, 14, 3, 1'b1);
    @(negedge clk);
    check("scan_y0", {48'd0, y}, 64'h4000);
    check("scan_rdy0", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("scan_y1", {48'd0, y}, 64'h8000);
    check("scan_rdy1", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("scan_y2", {48'd0, y}, 64'h0001);
    check("scan_rdy2", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("scan_y3", {48'd0, y}, 64'h0002);
    check("scan_rdy3", {63'd0, in_ready}, 64'd1);
    wait_idle();

    // Stall on the second word of a scan.
    issue(1'b1, 0, 2, 1'b1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_y", {48'd0, y}, 64'h0002);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // Randomized commands under random backpressure; en wiggles mid-scan.
    rdy_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, OUT_W - 1)),
            int'($urandom_range(0, (1 << LEN_W) - 1)), 1'($urandom_range(0, 3) != 0));
      len = LEN_W'($urandom);
      sel = SEL_W'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        en = 1'($urandom);
      end
    end
    wait_idle();
    fixed_ready();

    // Reset in the middle of a scan.
    issue(1'b1, 0, 7, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_y", {48'd0, y}, 64'd0);
    exp_q.delete();
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

    issue(1'b0, 3, 0, 1'b1);
    @(negedge clk);
    check("post_rst_y", {48'd0, y}, 64'h0008);
    for (int i = 0; i < 4; i++) issue(1'b0, i + 7, 0, 1'b1);
    issue(1'b1, 2, 3, 1'b1);
    wait_idle();
`ifdef SCAN_DECODER_CNT_EN
    check("word_cnt", {48'd0, word_cnt}, 64'd9);
    check("word_cnt_model", {48'd0, word_cnt}, 64'(hs_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_scan_decoder
